// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // 50 MHz system clock divided down to 9600 baud.
    localparam int UART_DEFAULT_CLK_DIV = 5208;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; extra pointer MSB separates full from empty.
module uart_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed start/data/[parity]/stop framer.
// Parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int CLK_DIV    = UART_DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 rw,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic                 full,
    output logic                 ovf
);

    localparam int CW = cnt_w(CLK_DIV);
    localparam int BW = cnt_w(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS out of range");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("uart_tx_fifo: CLK_DIV must be at least 2");
        end
        if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
            $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 empty;
    logic                 push;
    logic                 load;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    assign bit_end = (cnt == CNT_LAST);
    assign push    = rw && !full;
    // A word leaves the FIFO either from idle or straight out of the last stop bit.
    assign load    = !empty && ((state == ST_IDLE) ||
                                (state == ST_STOP && bit_end && stop_idx == STOP_LAST));

    uart_fifo #(
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_in(clk_in),
        .reset (reset),
        .push  (push),
        .pop   (load),
        .din   (din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // tx is registered from the current state, so the line trails the FSM by one clock.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            busy <= push || (state != ST_IDLE) || !empty;
            if (rw && full) begin
                ovf <= 1'b1;
            end
            if (load) begin
                shift <= fifo_dout;
`ifdef UART_TX_PARITY_EN
                par_bit <= (^fifo_dout) ^ (PARITY_ODD != 0);
`endif
            end

            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (load) begin
                        cnt   <= '0;
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    tx <= shift[0];
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == BIT_LAST) begin
                            stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            state    <= ST_PARITY;
`else
                            state    <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    tx <= par_bit;
                    if (bit_end) begin
                        cnt      <= '0;
                        stop_idx <= 1'b0;
                        state    <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            done  <= 1'b1;
                            state <= load ? ST_START : ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: framing, queuing, overflow, stop bits, parity, reset.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int CLK_DIV   = 16;
    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       rw     = 1'b0;
    logic [7:0] din    = 8'h00;
    logic       tx, busy, done, full, ovf;
    logic       rw2    = 1'b0;
    logic [7:0] din2   = 8'h00;
    logic       tx2, busy2, done2, full2, ovf2;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    int         r_ok, r_glitch, r_stop_hi, r_done_cnt, r_done_at;
    logic [7:0] r_data;
    logic       r_par;

    always #5 clk_in = ~clk_in;

    uart_tx_fifo #(
        .DATA_BITS(DATA_BITS), .STOP_BITS(1), .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) dut (
        .clk_in(clk_in), .reset(reset), .rw(rw), .din(din),
        .tx(tx), .busy(busy), .done(done), .full(full), .ovf(ovf)
    );

    uart_tx_fifo #(
        .DATA_BITS(DATA_BITS), .STOP_BITS(2), .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(4), .PARITY_ODD(1)
    ) dut2 (
        .clk_in(clk_in), .reset(reset), .rw(rw2), .din(din2),
        .tx(tx2), .busy(busy2), .done(done2), .full(full2), .ovf(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel == 0) ? tx : tx2;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done : done2;
    endfunction

    // Waits (bounded) for a start bit, then samples every clock of one frame.
    task automatic recv_frame(input int sel, input int stop_bits);
        int   len;
        int   b;
        logic cur;
        logic v;
        len = (1 + DATA_BITS + P + stop_bits) * CLK_DIV;
        r_ok = 0; r_glitch = 0; r_stop_hi = 0; r_done_cnt = 0; r_done_at = 0;
        r_data = 8'h00; r_par = 1'b0; cur = 1'b0;
        for (int t = 0; t < 4000 && tx_of(sel) !== 1'b0; t++) @(negedge clk_in);
        if (tx_of(sel) !== 1'b0) return;
        r_ok = 1;
        for (int i = 0; i < len; i++) begin
            v = tx_of(sel);
            b = i / CLK_DIV;
            if (i % CLK_DIV == 0) cur = v;
            else if (v !== cur) r_glitch++;
            if (i % CLK_DIV == CLK_DIV / 2) begin
                if (b >= 1 && b <= DATA_BITS) r_data[b-1] = v;
                if (P == 1 && b == DATA_BITS + 1) r_par = v;
            end
            if (b >= 1 + DATA_BITS + P && v === 1'b1) r_stop_hi++;
            if (done_of(sel) === 1'b1) begin
                r_done_cnt++;
                r_done_at = i + 1;
            end
            @(negedge clk_in);
        end
    endtask

    task automatic expect_frame(input string tag, input int stop_bits, input logic [7:0] exp_data);
        int len;
        len = (1 + DATA_BITS + P + stop_bits) * CLK_DIV;
        check({tag, "_found"}, r_ok, 1);
        check({tag, "_data"}, r_data, exp_data);
        check({tag, "_glitch"}, r_glitch, 0);
        check({tag, "_stop_hi"}, r_stop_hi, stop_bits * CLK_DIV);
        check({tag, "_done_cnt"}, r_done_cnt, 1);
        check({tag, "_done_at"}, r_done_at, len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;

        // Reset held for 50 clocks.
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) bad++;
            if (tx2 !== 1'b1 || busy2 !== 1'b0) bad++;
        end
        check("reset_hold", bad, 0);
        reset = 1'b0;

        // Single word 0x33.
        @(negedge clk_in);
        din = 8'h33; rw = 1'b1;
        @(negedge clk_in);
        rw = 1'b0;
        check("single_busy_rise", busy, 1);
        check("single_tx_n0", tx, 1);
        @(negedge clk_in);
        check("single_tx_n1", tx, 1);
        @(negedge clk_in);
        check("single_start_n2", tx, 0);
        recv_frame(0, 1);
        expect_frame("single", 1, 8'h33);
        check("single_busy_fall", busy, 0);
        check("single_done_low", done, 0);

        // Six-clock write burst into a depth-4 FIFO.
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    @(negedge clk_in);
                    if (i == 5) check("burst_full_before_w5", full, 0);
                    if (i == 6) begin
                        check("burst_full_after_w5", full, 1);
                        check("burst_ovf_before_w6", ovf, 0);
                    end
                    rw = 1'b1; din = 8'(i);
                end
                @(negedge clk_in);
                rw = 1'b0;
                check("burst_ovf_after_w6", ovf, 1);
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    recv_frame(0, 1);
                    expect_frame("burst", 1, exp_q.pop_front());
                    if (f < 4) check("burst_b2b_gap", tx, 0);
                end
            end
        join
        check("burst_busy_fall", busy, 0);
        check("burst_full_clear", full, 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("burst_no_extra_frame", bad, 0);
        check("burst_ovf_sticky", ovf, 1);

        // Two stop bits, 0xA5.
        @(negedge clk_in);
        din2 = 8'hA5; rw2 = 1'b1;
        @(negedge clk_in);
        rw2 = 1'b0;
        recv_frame(1, 2);
        expect_frame("stop2", 2, 8'hA5);
        check("stop2_busy_fall", busy2, 0);

`ifdef UART_TX_PARITY_EN
        @(negedge clk_in);
        din = 8'h07; rw = 1'b1;
        @(negedge clk_in);
        rw = 1'b0;
        recv_frame(0, 1);
        expect_frame("par_even", 1, 8'h07);
        check("par_even_bit", r_par, 1);

        @(negedge clk_in);
        din2 = 8'h07; rw2 = 1'b1;
        @(negedge clk_in);
        rw2 = 1'b0;
        recv_frame(1, 2);
        expect_frame("par_odd", 2, 8'h07);
        check("par_odd_bit", r_par, 0);
`endif

        // Reset in the middle of the second of three queued frames.
        @(negedge clk_in);
        rw = 1'b1; din = 8'h11;
        @(negedge clk_in);
        din = 8'h22;
        @(negedge clk_in);
        din = 8'h33;
        @(negedge clk_in);
        rw = 1'b0;
        recv_frame(0, 1);
        expect_frame("rst_f1", 1, 8'h11);
        repeat (CLK_DIV + 3 * CLK_DIV + CLK_DIV / 2) @(negedge clk_in);
        check("rst_pre_tx_bit3", tx, 0);
        check("rst_pre_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("rst_tx_same_cycle", tx, 1);
        check("rst_busy_clear", busy, 0);
        check("rst_full_clear", full, 0);
        check("rst_ovf_clear", ovf, 0);
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("rst_quiet_after", bad, 0);
        check("rst_fifo_empty", dut.u_fifo.empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter for the Bluetooth link path: accepts parallel words on a write strobe, buffers them in a small FIFO and serialises them LSB-first on `tx` as start/data/optional parity/stop frames at a divided baud rate. It succeeds the fixed 8N1 `transmision` block. Compared with that block, it has a generic word width, stop-bit count and baud divider, queues back-to-back words without software polling, and reports a sticky overflow.

## Interface
- `DATA_BITS`, 8: payload bits per frame, range 5..9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `CLK_DIV`, 5208: system clocks per bit period (for example 50 MHz / 9600), minimum 2.
- `FIFO_DEPTH`, 4: words buffered; must be a power of 2, range 2..16.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; only used when parity is compiled in.

- `clk_in`  in  1  system clock, all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rw`  in  1  write strobe; each sampled-high cycle pushes `din` if not full.
- `din`  in  DATA_BITS  word to transmit.
- `tx`  out  1  serial line, idles high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `done`  out  1  one-cycle pulse in the last clock of each frame's final stop bit.
- `full`  out  1  FIFO holds FIFO_DEPTH words.
- `ovf`  out  1  sticky: a write was attempted while `full`; cleared only by `reset`.

## Operation
- Reset (asynchronous, immediate) forces:
  - `tx`=1, `busy`=0, `done`=0, `full`=0, `ovf`=0.
  - FIFO emptied and FSM in IDLE, even if a frame is in progress; the partial frame is lost.
- Write: `rw`=1 and `full`=0 at an edge stores `din`.
  - `rw`=1 and `full`=1 drops the word and sets `ovf`.
  - A same-cycle pop does not make room for that push.
  - Holding `rw` high pushes one word per clock.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx`=1. With the FIFO non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for one bit period, then DATA.
  - DATA: send shift[0] for one bit period, then shift right. After DATA_BITS bits, go to PARITY (parity compiled in) or STOP.
  - PARITY: `tx` = XOR of the payload, inverted when PARITY_ODD=1.
  - STOP: `tx`=1 for STOP_BITS bit periods. At the end, pulse `done`. If the FIFO is non-empty, pop and enter START on the next clock (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLK_DIV-1 with width $clog2(CLK_DIV).
  - Reloads to 0 on every state entry.
  - The bit ends when the count equals CLK_DIV-1.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full and empty come from the pointer MSB comparison.

## Timing
- Write at edge N into an empty FIFO while IDLE:
  - pop at edge N+1;
  - `tx` falls after edge N+2.
- Bit period: exactly CLK_DIV clocks.
- Frame length: (1 + DATA_BITS + P + STOP_BITS)·CLK_DIV clocks, where P=1 with parity, else 0.
- Back-to-back frames: the next start bit begins the clock after `done`.
- `busy` is registered. It rises the clock after an accepted write and falls the clock after the final `done` with the FIFO empty.
- `full` updates the clock after the push or pop that changes it.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the PARITY state and parity generator are built;
  - frame includes one parity bit after the data;
  - PARITY_ODD selects the sense.
- Not defined:
  - no PARITY state and no parity logic;
  - PARITY_ODD is ignored;
  - frame goes straight from the last data bit to STOP.

## Structure
- Package `uart_pkg` holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - localparam helpers for counter widths;
  - shared default CLK_DIV for 50 MHz / 9600.
- Sub-module `uart_fifo`: synchronous FIFO with parameters DATA_BITS and FIFO_DEPTH, ports push/pop/din/dout/full/empty. The top holds the FSM, baud counter and shift register.

## Test plan
- Bench parameters throughout: CLK_DIV=16, DATA_BITS=8, STOP_BITS=1.
- Reset held for 50 clocks → `tx`=1, `busy`=0, `full`=0, `ovf`=0 for the whole interval.
- Single write, `din`=0x33 (parity off) → line reads 0, then 1,1,0,0,1,1,0,0 (LSB first), then 1. Each bit lasts 16 clocks. `done` pulses once, 160 clocks after the start bit falls.
- Hold `rw` high for 6 clocks with FIFO_DEPTH=4, `din`=0x01..0x06, one word per clock (write N carries 0x0N):
  - the FSM pops 0x01 on the clock after its write, freeing one slot;
  - writes 1–5 are accepted: 0x01 goes on the line and 0x02..0x05 fill the FIFO;
  - `full` rises after write 5;
  - write 6 (0x06) is dropped and `ovf`=1;
  - five contiguous frames follow with no idle gap, then `busy`=0.
- With `UART_TX_PARITY_EN` and PARITY_ODD=0, `din`=0x07 → parity bit 1. With PARITY_ODD=1 → parity bit 0. Frame length is 176 clocks.
- STOP_BITS=2, `din`=0xA5 → stop high for 32 clocks before `done`.
- Assert `reset` mid-DATA of the second of three queued words → `tx`=1 within the same cycle. After release, FIFO empty, `busy`=0 and no further frames.
